spi_script_sequencer: RTL and testbench

- Generic, table-driven command sequencer for the SPI peripheral controllers (TM1638, HT16D35A and similar).
- Replaces hand-coded per-board init state machines.
- After a power-up wait, it walks a script held in an external synchronous ROM, one entry at a time. Each entry is sent as one SPI transaction over the busy/activate handshake, followed by an optional post-delay.
- Supports chip-select masks, pure-delay entries, looping, abort and a busy-handshake timeout.

---
 rtl/spi_script_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_spi_script_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_script_sequencer.sv
// spi_script_sequencer
//   Walks a command script held in an external synchronous ROM and sends each
//   entry as one SPI transaction over the busy/activate handshake. Each entry
//   can add a post-delay. The sequencer waits a power-up interval after reset
//   and also supports delay-only entries, looping, abort and a timeout on the
//   busy handshake.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start               runs the script from entry 0 (sampled only in S_IDLE)
//   abort               stop once the current transaction/delay completes
//   running             high while a script is executing
//   done                one-cycle pulse on normal completion
//   error               sticky busy-handshake timeout flag
//   step                index of the current entry
//   rom_addr            script ROM address (read latency 1 cycle)
//   rom_data/count/cs/delay/last   script entry fields
//                       (rom_count == 0 marks a delay-only entry)
//   busy                handshake from the SPI controller
//   activate, in_cs, out_data, out_count   request to the SPI controller
module spi_script_sequencer #(
  parameter int OUT_BYTES       = 5,
  parameter int OUT_BYTES_SZ    = $clog2(OUT_BYTES + 1),
  parameter int NUM_SELECTS     = 1,
  parameter int ADDR_W          = 6,
  parameter int DELAY_W         = 24,
  parameter int POWER_UP_CYCLES = 50_000_000,
  parameter int AUTO_START      = 1,
  parameter int LOOP            = 0,
  parameter int LOOP_START      = 0,
  parameter int BUSY_TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     running,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_W-1:0]        step,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [8*OUT_BYTES-1:0]   rom_data,
  input  logic [OUT_BYTES_SZ-1:0]  rom_count,
  input  logic [NUM_SELECTS-1:0]   rom_cs,
  input  logic [DELAY_W-1:0]       rom_delay,
  input  logic                     rom_last,
  input  logic                     busy,
  output logic                     activate,
  output logic [NUM_SELECTS-1:0]   in_cs,
  output logic [8*OUT_BYTES-1:0]   out_data,
  output logic [OUT_BYTES_SZ-1:0]  out_count
);

  localparam int PU_W = (POWER_UP_CYCLES < 2) ? 1 : $clog2(POWER_UP_CYCLES + 1);
  // The timeout counter only needs to reach BUSY_TIMEOUT-1.
  localparam int TO_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_POWER_UP,
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_AWAIT,
    S_DELAY
  } state_t;

  state_t              state_q, state_d;
  logic [PU_W-1:0]     pu_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [DELAY_W-1:0]  dly_cnt;
  logic                last_q;
  logic                busy_seen;
  logic                abort_q;
  logic                busy_tmo;
  logic                dly_done;

  // Next state and decoded events
  always_comb begin
    state_d  = state_q;
    busy_tmo = 1'b0;
    dly_done = 1'b0;
    running  = (state_q != S_IDLE) && (state_q != S_POWER_UP);
    rom_addr = step;
    case (state_q)
      S_POWER_UP: if (pu_cnt <= PU_W'(1)) state_d = (AUTO_START != 0) ? S_FETCH : S_IDLE;
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    state_d = S_LATCH;
      S_LATCH:    state_d = (rom_count == '0) ? S_DELAY : S_SEND;
      S_SEND:     if (!busy) state_d = S_AWAIT;
      S_AWAIT: begin
        if (busy_seen) begin
          if (!busy) state_d = S_DELAY;
        end else if (!busy && to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
          // A busy rise on the expiry cycle still counts as a response.
          busy_tmo = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DELAY: begin
        if (dly_cnt == '0) begin
          dly_done = 1'b1;
          if (abort_q || (last_q && LOOP == 0)) state_d = S_IDLE;
          else                                  state_d = S_FETCH;
        end
      end
      default: state_d = S_POWER_UP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_POWER_UP;
    else       state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pu_cnt    <= PU_W'(POWER_UP_CYCLES);
      to_cnt    <= '0;
      dly_cnt   <= '0;
      last_q    <= 1'b0;
      busy_seen <= 1'b0;
      abort_q   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      step      <= '0;
      activate  <= 1'b0;
      in_cs     <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      done <= 1'b0;

      // Abort is remembered until the script returns to idle. It is ignored
      // during power-up and in idle, except when it coincides with start.
      if (state_q != S_IDLE && state_d == S_IDLE)
        abort_q <= 1'b0;
      else if (abort && state_q != S_POWER_UP && (state_q != S_IDLE || start))
        abort_q <= 1'b1;

      case (state_q)
        S_POWER_UP: begin
          if (pu_cnt != '0) pu_cnt <= pu_cnt - PU_W'(1);
          if (state_d == S_FETCH) step <= '0;
        end
        S_IDLE: begin
          if (start) begin
            error <= 1'b0;
            step  <= '0;
          end
        end
        S_LATCH: begin
          out_data  <= rom_data;
          out_count <= rom_count;
          in_cs     <= rom_cs;
          dly_cnt   <= rom_delay;
          last_q    <= rom_last;
        end
        S_SEND: begin
          if (!busy) begin
            activate  <= 1'b1;
            to_cnt    <= '0;
            busy_seen <= 1'b0;
          end
        end
        S_AWAIT: begin
          if (!busy_seen) begin
            if (busy) begin
              busy_seen <= 1'b1;
              activate  <= 1'b0;
            end else if (busy_tmo) begin
              activate <= 1'b0;
              error    <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        S_DELAY: begin
          if (!dly_done) begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
          end else if (!abort_q) begin
            // The step counter wraps naturally at 2^ADDR_W.
            if (!last_q)        step <= step + ADDR_W'(1);
            else if (LOOP != 0) step <= ADDR_W'(LOOP_START);
            else                done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_script_sequencer.sv
// Testbench for spi_script_sequencer.
// Two instances share clk/reset: m_* (AUTO_START, no loop, BUSY_TIMEOUT=16)
// and l_* (LOOP from entry 1, manual start). Script entries come from one
// table; transactions expected from it are queued when a script is started
// and popped as each activate rises.
module tb_spi_script_sequencer;
  localparam int OB = 5, OBS = 3, NS = 2, AW = 4, DW = 16;

  typedef struct {
    logic [39:0] data;
    logic [2:0]  cnt;
    logic [1:0]  cs;
    logic [15:0] dly;
    logic        last;
    logic [3:0]  idx;    // ROM position == expected step during the entry
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  ent_t vec[13];
  ent_t m_rom[16];
  ent_t l_rom[16];
  ent_t mq[$];
  ent_t lq[$];

  // main instance signals
  logic m_start = 1'b0, m_abort = 1'b0;
  logic m_running, m_done, m_error, m_activate;
  logic [AW-1:0] m_step, m_rom_addr;
  logic [8*OB-1:0] m_rom_data, m_out_data;
  logic [OBS-1:0] m_rom_count, m_out_count;
  logic [NS-1:0] m_rom_cs, m_in_cs;
  logic [DW-1:0] m_rom_delay;
  logic m_rom_last;
  logic m_busy = 1'b0;

  // loop instance signals
  logic l_start = 1'b0, l_abort = 1'b0;
  logic l_running, l_done, l_error, l_activate;
  logic [AW-1:0] l_step, l_rom_addr;
  logic [8*OB-1:0] l_rom_data, l_out_data;
  logic [OBS-1:0] l_rom_count, l_out_count;
  logic [NS-1:0] l_rom_cs, l_in_cs;
  logic [DW-1:0] l_rom_delay;
  logic l_rom_last;
  logic l_busy = 1'b0;

  spi_script_sequencer #(
    .OUT_BYTES(OB), .NUM_SELECTS(NS), .ADDR_W(AW), .DELAY_W(DW),
    .POWER_UP_CYCLES(10), .AUTO_START(1), .LOOP(0), .LOOP_START(0), .BUSY_TIMEOUT(16)
  ) u_dut (
    .clk(clk), .reset(reset), .start(m_start), .abort(m_abort),
    .running(m_running), .done(m_done), .error(m_error), .step(m_step),
    .rom_addr(m_rom_addr), .rom_data(m_rom_data), .rom_count(m_rom_count),
    .rom_cs(m_rom_cs), .rom_delay(m_rom_delay), .rom_last(m_rom_last),
    .busy(m_busy), .activate(m_activate), .in_cs(m_in_cs),
    .out_data(m_out_data), .out_count(m_out_count)
  );

  spi_script_sequencer #(
    .OUT_BYTES(OB), .NUM_SELECTS(NS), .ADDR_W(AW), .DELAY_W(DW),
    .POWER_UP_CYCLES(4), .AUTO_START(0), .LOOP(1), .LOOP_START(1), .BUSY_TIMEOUT(16)
  ) u_loop (
    .clk(clk), .reset(reset), .start(l_start), .abort(l_abort),
    .running(l_running), .done(l_done), .error(l_error), .step(l_step),
    .rom_addr(l_rom_addr), .rom_data(l_rom_data), .rom_count(l_rom_count),
    .rom_cs(l_rom_cs), .rom_delay(l_rom_delay), .rom_last(l_rom_last),
    .busy(l_busy), .activate(l_activate), .in_cs(l_in_cs),
    .out_data(l_out_data), .out_count(l_out_count)
  );

  // Synchronous script ROMs, one cycle read latency
  always @(posedge clk) begin
    m_rom_data  <= m_rom[m_rom_addr].data;
    m_rom_count <= m_rom[m_rom_addr].cnt;
    m_rom_cs    <= m_rom[m_rom_addr].cs;
    m_rom_delay <= m_rom[m_rom_addr].dly;
    m_rom_last  <= m_rom[m_rom_addr].last;
    l_rom_data  <= l_rom[l_rom_addr].data;
    l_rom_count <= l_rom[l_rom_addr].cnt;
    l_rom_cs    <= l_rom[l_rom_addr].cs;
    l_rom_delay <= l_rom[l_rom_addr].dly;
    l_rom_last  <= l_rom[l_rom_addr].last;
  end

  // SPI controller models: mode 0 answers activate with 8 cycles of busy,
  // mode 1 never answers, mode 2 holds busy high.
  int m_mode = 0;
  int m_bc = 0;
  int l_bc = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0; m_bc <= 0;
    end else if (m_mode == 2) begin
      m_busy <= 1'b1;
    end else if (m_busy) begin
      if (m_bc <= 1) m_busy <= 1'b0;
      m_bc <= (m_bc > 0) ? m_bc - 1 : 0;
    end else if (m_activate && m_mode == 0) begin
      m_busy <= 1'b1; m_bc <= 8;
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      l_busy <= 1'b0; l_bc <= 0;
    end else if (l_busy) begin
      if (l_bc <= 1) l_busy <= 1'b0;
      l_bc <= (l_bc > 0) ? l_bc - 1 : 0;
    end else if (l_activate) begin
      l_busy <= 1'b1; l_bc <= 8;
    end
  end

  // Event counters
  int m_done_cnt = 0, m_act_cnt = 0, l_act_cnt = 0;
  logic m_act_d = 1'b0, l_act_d = 1'b0, l_done_seen = 1'b0;
  always @(posedge clk) begin
    m_act_d <= m_activate;
    l_act_d <= l_activate;
    if (m_done) m_done_cnt <= m_done_cnt + 1;
    if (l_done) l_done_seen <= 1'b1;
    if (m_activate && !m_act_d) m_act_cnt <= m_act_cnt + 1;
    if (l_activate && !l_act_d) l_act_cnt <= l_act_cnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic act_of(input int k);
    return (k == 0) ? m_activate : l_activate;
  endfunction

  task automatic load(input int k, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (k == 0) m_rom[i] = vec[first + i];
      else        l_rom[i] = vec[first + i];
    end
  endtask

  task automatic push(input int k, input int first, input int n);
    for (int i = first; i < first + n; i++)
      if (vec[i].cnt != 0) begin
        if (k == 0) mq.push_back(vec[i]);
        else        lq.push_back(vec[i]);
      end
  endtask

  // Wait for the next activate, score it against the queue, wait for it to drop.
  task automatic score(input int k, input string name, output int tr, output int tf);
    ent_t e;
    int n;
    n = 0;
    while (!act_of(k) && n < 400) begin tick(); n++; end
    tr = cyc;
    chk({name, " activate_rise"}, act_of(k), 1);
    if ((k == 0 && mq.size() == 0) || (k != 0 && lq.size() == 0)) begin
      checks++; failures++;
      $display("FAIL %s: activate with no expected transaction", name);
    end else begin
      if (k == 0) begin
        e = mq.pop_front();
        chk({name, " out_count"}, m_out_count, e.cnt);
        chk({name, " out_data"}, m_out_data, e.data);
        chk({name, " in_cs"}, m_in_cs, e.cs);
        chk({name, " step"}, m_step, e.idx);
      end else begin
        e = lq.pop_front();
        chk({name, " out_count"}, l_out_count, e.cnt);
        chk({name, " out_data"}, l_out_data, e.data);
        chk({name, " in_cs"}, l_in_cs, e.cs);
        chk({name, " step"}, l_step, e.idx);
      end
    end
    n = 0;
    while (act_of(k) && n < 400) begin tick(); n++; end
    tf = cyc;
    chk({name, " activate_drop"}, act_of(k), 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!m_done && n < 400) begin tick(); n++; end
    chk({name, " done"}, m_done, 1);
    chk({name, " running_low"}, m_running, 0);
    tick();
    chk({name, " done_one_cycle"}, m_done, 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " activate"}, m_activate, 0);
    chk({name, " running"}, m_running, 0);
    chk({name, " done"}, m_done, 0);
    chk({name, " error"}, m_error, 0);
    chk({name, " step"}, m_step, 0);
    chk({name, " rom_addr"}, m_rom_addr, 0);
    chk({name, " out_count"}, m_out_count, 0);
    chk({name, " out_data"}, m_out_data, 0);
    chk({name, " in_cs"}, m_in_cs, 0);
  endtask

  task automatic pulse_m_start();
    m_start = 1'b1; tick(); m_start = 1'b0;
  endtask

  initial begin
    int tr, tf, t0, ts, n, a0, d0;
    // {data, count, cs, delay, last, idx}; byte 0 in bits [7:0]
    vec[0]  = '{40'h40,           3'd1, 2'b01, 16'd0,   1'b0, 4'd0};
    vec[1]  = '{40'hAA_AAAA_AAC0, 3'd5, 2'b01, 16'd0,   1'b0, 4'd1};
    vec[2]  = '{40'h8F,           3'd1, 2'b01, 16'd0,   1'b1, 4'd2};
    vec[3]  = '{40'h12,           3'd1, 2'b10, 16'd0,   1'b0, 4'd0};
    vec[4]  = '{40'h0,            3'd0, 2'b10, 16'd100, 1'b0, 4'd1};
    vec[5]  = '{40'h5634,         3'd2, 2'b10, 16'd3,   1'b1, 4'd2};
    vec[6]  = '{40'h77,           3'd1, 2'b11, 16'd0,   1'b1, 4'd0};
    vec[7]  = '{40'hA1,           3'd1, 2'b01, 16'd2,   1'b0, 4'd0};
    vec[8]  = '{40'hB2,           3'd1, 2'b10, 16'd2,   1'b0, 4'd1};
    vec[9]  = '{40'hC3,           3'd1, 2'b11, 16'd2,   1'b1, 4'd2};
    vec[10] = '{40'h5A,           3'd1, 2'b01, 16'd1,   1'b0, 4'd0};
    vec[11] = '{40'h6B,           3'd1, 2'b01, 16'd1,   1'b0, 4'd1};
    vec[12] = '{40'h7C,           3'd1, 2'b01, 16'd1,   1'b1, 4'd2};
    for (int i = 0; i < 16; i++) begin
      m_rom[i] = '{40'h0, 3'd0, 2'b00, 16'd0, 1'b1, 4'd0};
      l_rom[i] = '{40'h0, 3'd0, 2'b00, 16'd0, 1'b1, 4'd0};
    end

    // Power-up auto-run of the TM1638 script
    load(0, 0, 3); push(0, 0, 3);
    load(1, 7, 3);
    tick(3);
    chk_zero("reset");
    reset = 1'b0;
    t0 = cyc;
    score(0, "tm_e0", tr, tf);
    chk("tm powerup_latency", tr - t0, 13);
    score(0, "tm_e1", tr, tf);
    chk("tm running", m_running, 1);
    score(0, "tm_e2", tr, tf);
    wait_done("tm");
    tick(20);
    chk("tm done_count", m_done_cnt, 1);

    // Delay-only entry between two transactions. From the tick where busy is
    // seen low: 1 (sampled) + 1 DELAY(0) + 2 FETCH/LATCH + 101 DELAY(100)
    // + 2 FETCH/LATCH + 1 SEND = 108 cycles to the entry-2 activate.
    load(0, 3, 3); push(0, 3, 3);
    pulse_m_start();
    score(0, "dly_e0", tr, tf);
    n = 0;
    while (m_busy && n < 50) begin tick(); n++; end
    ts = cyc;
    score(0, "dly_e2", tr, tf);
    chk("dly gap", tr - ts, 108);
    wait_done("dly");

    // Busy timeout: no response from the controller
    load(0, 6, 1); push(0, 6, 1);
    m_mode = 1;
    d0 = m_done_cnt;
    pulse_m_start();
    ts = cyc;
    score(0, "tmo", tr, tf);
    chk("tmo start_latency", tr - ts, 3);
    chk("tmo activate_width", tf - tr, 16);
    chk("tmo error", m_error, 1);
    chk("tmo running", m_running, 0);
    tick(5);
    chk("tmo error_sticky", m_error, 1);
    chk("tmo no_done", m_done_cnt, d0);
    m_mode = 0;
    push(0, 6, 1);
    pulse_m_start();
    chk("tmo error_cleared", m_error, 0);
    score(0, "tmo_retry", tr, tf);
    wait_done("tmo_retry");

    // Busy already high in S_SEND for a long time
    m_mode = 2;
    tick(2);
    push(0, 6, 1);
    pulse_m_start();
    tick(5000);
    chk("hold activate", m_activate, 0);
    chk("hold error", m_error, 0);
    m_mode = 0;
    tick();
    chk("hold busy_fell_no_act", m_activate, 0);
    tick();
    chk("hold act_after_fall", m_activate, 1);
    score(0, "hold", tr, tf);
    wait_done("hold");

    // Abort together with start: entry 0 only, no done
    load(0, 10, 3); push(0, 10, 1);
    d0 = m_done_cnt;
    a0 = m_act_cnt;
    m_start = 1'b1; m_abort = 1'b1;
    tick();
    m_start = 1'b0; m_abort = 1'b0;
    score(0, "abs", tr, tf);
    n = 0;
    while (m_running && n < 100) begin tick(); n++; end
    chk("abs running_low", m_running, 0);
    tick(30);
    chk("abs one_txn", m_act_cnt - a0, 1);
    chk("abs no_done", m_done_cnt, d0);

    // Looping instance: 0,1,2,1,2 then abort during entry 2
    push(1, 7, 3); push(1, 8, 2);
    l_start = 1'b1; tick(); l_start = 1'b0;
    score(1, "lp0", tr, tf);
    score(1, "lp1", tr, tf);
    score(1, "lp2", tr, tf);
    score(1, "lp3", tr, tf);
    score(1, "lp4", tr, tf);
    l_abort = 1'b1; tick(); l_abort = 1'b0;
    chk("lp running_after_abort", l_running, 1);
    n = 0;
    while (l_running && n < 100) begin tick(); n++; end
    chk("lp running_low", l_running, 0);
    tick(40);
    chk("lp act_count", l_act_cnt, 5);
    chk("lp no_done", l_done_seen, 0);
    chk("lp step_final", l_step, 2);

    // Reset while waiting for busy to fall
    load(0, 0, 3); push(0, 0, 1);
    pulse_m_start();
    score(0, "rst_e0", tr, tf);
    chk("rst in_await", m_running, 1);
    reset = 1'b1;
    tick();
    chk_zero("rst_await");
    reset = 1'b0;
    t0 = cyc;
    push(0, 0, 3);
    score(0, "rst_e0b", tr, tf);
    chk("rst powerup_latency", tr - t0, 13);
    score(0, "rst_e1b", tr, tf);
    score(0, "rst_e2b", tr, tf);
    wait_done("rst");

    chk("main queue_empty", mq.size(), 0);
    chk("loop queue_empty", lq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
